uart_xcvr_param: RTL and testbench
==================================

// Module: uart_xcvr_param
// PURPOSE
//  Parametrised synthesizable UART transceiver for the e203 SoC demo: TX with FIFO plus RX with mid-bit sampling.
//  Replaces fixed 8N1 / 115200 stimulus with runtime-configurable baud divisor, parity and stop bits.
//  Sits between the GPIO UART pins (gpio[16] rx-in / gpio[17] tx-out) and a valid/ready byte interface.
//  Also reused in benches as a cycle-accurate UART stimulus/monitor in place of delay-based tasks.
// PARAMETERS
//  DATA_W    8   payload bits per frame, legal 5..9
//  DIV_W     16  width of baud divisor
//  FIFO_AW   3   TX FIFO address bits; depth = 2**FIFO_AW
// PORTS
//  clk            in   1        system clock (hfclk domain)
//  rst_n          in   1        synchronous reset, active low
//  cfg_div        in   DIV_W    bit period = cfg_div+1 clocks; legal >= 3
//  cfg_parity     in   2        00 none, 01 odd, 10 even, 11 none
//  cfg_stop2      in   1        1 = two stop bits on TX; RX always checks first stop only
//  tx_data        in   DATA_W   byte to send
//  tx_valid       in   1        push request
//  tx_ready       out  1        FIFO not full
//  tx_level       out  FIFO_AW+1 FIFO occupancy
//  tx_busy        out  1        FIFO non-empty or frame in progress
//  tx_pin         out  1        serial out, idle high
//  rx_pin         in   1        serial in, asynchronous
//  rx_data        out  DATA_W   received payload
//  rx_valid       out  1        rx_data holds unread frame
//  rx_ready       in   1        consumer accepts rx_data
//  rx_frame_err   out  1        stop bit sampled low (sticky per frame, travels with rx_data)
//  rx_parity_err  out  1        parity mismatch (travels with rx_data)
//  rx_overrun     out  1        sticky: frame completed while rx_valid=1; cleared by reset only
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): tx_pin=1, tx_ready=1, tx_level=0, tx_busy=0, rx_valid=0, rx_data=0, all err flags 0, both FSMs IDLE, FIFO pointers 0.
//  Config sampled at frame start (TX: leaving IDLE; RX: start detected); mid-frame changes ignored until next frame.
//  TX FIFO: push when tx_valid&&tx_ready; push while full ignored. Simultaneous push+pop when full allowed only via pop first (tx_ready reflects pre-pop state).
//  TX FSM: IDLE -> START -> DATA (DATA_W bits, LSB first) -> PARITY (if enabled) -> STOP1 -> STOP2 (if cfg_stop2) -> IDLE/START.
//   Each state held exactly cfg_div+1 clocks via down-counter; pop occurs on IDLE->START transition.
//   tx_pin registered; first start-bit low appears 1 clock after pop. Back-to-back frames: STOP->START with no idle gap if FIFO non-empty.
//   Parity bit: even = ^data, odd = ~^data.
//  RX sync: rx_pin through 2-FF synchroniser (2-clock latency, counted from sync output).
//  RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
//   IDLE: falling edge on synced rx -> START, counter loaded with cfg_div>>1.
//   START: at count 0 resample; low -> DATA (counter = cfg_div), high -> IDLE (glitch rejected, no flags).
//   DATA/PARITY/STOP: sample once per bit period at counter 0 (mid-bit); shift in LSB first.
//   At STOP sample: rx_data, rx_frame_err (stop==0), rx_parity_err loaded; rx_valid set next clock. If rx_valid already 1 and not accepted same clock: data dropped, rx_overrun set, old rx_data kept.
//   rx_valid cleared on rx_valid&&rx_ready; simultaneous clear+new frame -> new frame wins, no overrun.
//   Frame error still returns to IDLE; a low line after stop requires a fresh falling edge (break does not retrigger).
//  Width rules: tx_level saturates never (max 2**FIFO_AW); counters DIV_W bits, no wrap beyond reload.
//  Reset mid-frame: both FSMs abort immediately to IDLE, tx_pin=1 next edge, FIFO contents discarded.
//  cfg_div < 3 is illegal; behaviour undefined, bench must not drive it.
// TESTING
//  T1 DATA_W=8, cfg_div=3, parity none, stop1; push 0xA5 -> tx_pin = 0,1,0,1,0,0,1,0,1,1 each 4 clocks; loopback rx_data=0xA5, no errors.
//  T2 cfg_parity=10 even, push 0x07 -> parity bit 1; odd mode same byte -> parity bit 0; RX with corrupted parity -> rx_parity_err=1, rx_data=0x07.
//  T3 FIFO_AW=3, push 9 bytes 0x00..0x08 with tx_valid held -> tx_ready low after 8 accepted (one pops), all 9 sent back-to-back, no idle gap, tx_busy falls after last stop.
//  T4 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun=1; then rx_ready=1 -> rx_valid drops.
//  T5 2-clock low glitch on rx_pin with cfg_div=15 -> no rx_valid; stop bit forced low -> rx_frame_err=1.
//  T6 assert rst_n=0 during DATA of TX frame with 3 bytes queued -> tx_pin=1, tx_level=0, tx_busy=0 next cycle; next push sends cleanly.

Source files
------------

// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: UART transceiver with a TX FIFO, a runtime baud divisor,
// optional odd/even parity and one or two TX stop bits. RX samples mid-bit
// after a 2-FF synchroniser. Every state lasts cfg_div+1 clocks.
module uart_xcvr_param #(
  parameter int DATA_W  = 8,
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [FIFO_AW:0]  tx_level,
  output logic              tx_busy,
  output logic              tx_pin,
  input  logic              rx_pin,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);
  localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0]  fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               push, pop;
  logic [DATA_W-1:0]  fifo_head;

  assign tx_ready  = (fifo_cnt != FULL_LEVEL);
  assign push      = tx_valid && tx_ready;
  assign tx_level  = fifo_cnt;
  assign fifo_head = fifo_mem[rd_ptr];

  // FIFO pointers and occupancy; a push while full is simply not accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tx_data;
  end

  // ---------------- TX FSM ----------------
  tx_state_t         tx_state, tx_state_d;
  logic [DIV_W-1:0]  tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [BIT_W-1:0]  tx_bit, tx_bit_d;
  logic [DATA_W-1:0] tx_shift, tx_shift_d;
  logic              tx_par_en, tx_par_en_d, tx_par_val, tx_par_val_d;
  logic              tx_stop2, tx_stop2_d, tx_pin_d;
  logic              tx_launch, tx_cnt_zero;

  assign tx_cnt_zero = (tx_cnt == '0);
  assign tx_busy     = (fifo_cnt != '0) || (tx_state != TX_IDLE);

  // TX next state; the pin value is computed here so tx_pin is a clean register
  always_comb begin
    tx_state_d   = tx_state;
    tx_cnt_d     = tx_cnt_zero ? tx_cnt : tx_cnt - 1'b1;
    tx_div_d     = tx_div;
    tx_bit_d     = tx_bit;
    tx_shift_d   = tx_shift;
    tx_par_en_d  = tx_par_en;
    tx_par_val_d = tx_par_val;
    tx_stop2_d   = tx_stop2;
    tx_pin_d     = tx_pin;
    tx_launch    = 1'b0;
    pop          = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_pin_d  = 1'b1;
        tx_launch = (fifo_cnt != '0);
      end
      TX_START: begin
        if (tx_cnt_zero) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = tx_div;
          tx_bit_d   = '0;
          tx_pin_d   = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_zero) begin
          tx_cnt_d = tx_div;
          if (tx_bit == LAST_BIT) begin
            if (tx_par_en) begin
              tx_state_d = TX_PARITY;
              tx_pin_d   = tx_par_val;
            end else begin
              tx_state_d = TX_STOP1;
              tx_pin_d   = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit + 1'b1;
            tx_shift_d = tx_shift >> 1;
            tx_pin_d   = tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_cnt_zero) begin
          tx_state_d = TX_STOP1;
          tx_cnt_d   = tx_div;
          tx_pin_d   = 1'b1;
        end
      end
      TX_STOP1: begin
        if (tx_cnt_zero) begin
          if (tx_stop2) begin
            tx_state_d = TX_STOP2;
            tx_cnt_d   = tx_div;
            tx_pin_d   = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
            tx_pin_d   = 1'b1;
            tx_launch  = (fifo_cnt != '0);
          end
        end
      end
      TX_STOP2: begin
        if (tx_cnt_zero) begin
          tx_state_d = TX_IDLE;
          tx_pin_d   = 1'b1;
          tx_launch  = (fifo_cnt != '0);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_pin_d   = 1'b1;
      end
    endcase
    if (tx_launch) begin
      pop          = 1'b1;
      tx_state_d   = TX_START;
      tx_cnt_d     = cfg_div;
      tx_div_d     = cfg_div;
      tx_bit_d     = '0;
      tx_shift_d   = fifo_head;
      tx_par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      tx_par_val_d = (cfg_parity == 2'b01) ? ~^fifo_head : ^fifo_head;
      tx_stop2_d   = cfg_stop2;
      tx_pin_d     = 1'b0;
    end
  end

  // TX state register; reset forces the line idle on the next edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_div     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_val <= 1'b0;
      tx_stop2   <= 1'b0;
      tx_pin     <= 1'b1;
    end else begin
      tx_state   <= tx_state_d;
      tx_cnt     <= tx_cnt_d;
      tx_div     <= tx_div_d;
      tx_bit     <= tx_bit_d;
      tx_shift   <= tx_shift_d;
      tx_par_en  <= tx_par_en_d;
      tx_par_val <= tx_par_val_d;
      tx_stop2   <= tx_stop2_d;
      tx_pin     <= tx_pin_d;
    end
  end

  // ---------------- RX ----------------
  logic rx_meta, rx_sync, rx_sync_q, rx_fall;

  assign rx_fall = rx_sync_q && !rx_sync;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta   <= rx_pin;
      rx_sync   <= rx_meta;
      rx_sync_q <= rx_sync;
    end
  end

  rx_state_t         rx_state, rx_state_d;
  logic [DIV_W-1:0]  rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [BIT_W-1:0]  rx_bit, rx_bit_d;
  logic [DATA_W-1:0] rx_shift, rx_shift_d;
  logic              rx_par_en, rx_par_en_d, rx_par_odd, rx_par_odd_d;
  logic              rx_par_bit, rx_par_bit_d;
  logic              rx_done, rx_cnt_zero, rx_par_bad;

  assign rx_cnt_zero = (rx_cnt == '0);
  assign rx_par_bad  = rx_par_en &&
                       (rx_par_bit != (rx_par_odd ? ~^rx_shift : ^rx_shift));

  // RX next state; the start bit is re-checked half a period after the edge
  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt_zero ? rx_cnt : rx_cnt - 1'b1;
    rx_div_d     = rx_div;
    rx_bit_d     = rx_bit;
    rx_shift_d   = rx_shift;
    rx_par_en_d  = rx_par_en;
    rx_par_odd_d = rx_par_odd;
    rx_par_bit_d = rx_par_bit;
    rx_done      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d   = RX_START;
          rx_cnt_d     = cfg_div >> 1;
          rx_div_d     = cfg_div;
          rx_par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          rx_par_odd_d = (cfg_parity == 2'b01);
        end
      end
      RX_START: begin
        if (rx_cnt_zero) begin
          if (!rx_sync) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = rx_div;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_zero) begin
          rx_cnt_d   = rx_div;
          rx_shift_d = {rx_sync, rx_shift[DATA_W-1:1]};
          if (rx_bit == LAST_BIT) begin
            rx_state_d = rx_par_en ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_cnt_zero) begin
          rx_par_bit_d = rx_sync;
          rx_state_d   = RX_STOP;
          rx_cnt_d     = rx_div;
        end
      end
      RX_STOP: begin
        if (rx_cnt_zero) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_div     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_div     <= rx_div_d;
      rx_bit     <= rx_bit_d;
      rx_shift   <= rx_shift_d;
      rx_par_en  <= rx_par_en_d;
      rx_par_odd <= rx_par_odd_d;
      rx_par_bit <= rx_par_bit_d;
    end
  end

  // Output holding register; an unread frame is kept and a new one dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (rx_done) begin
      if (rx_valid && !rx_ready) begin
        rx_overrun <= 1'b1;
      end else begin
        rx_data       <= rx_shift;
        rx_frame_err  <= !rx_sync;
        rx_parity_err <= rx_par_bad;
        rx_valid      <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_xcvr_param.sv
// tb_uart_xcvr_param: directed bench for uart_xcvr_param (8 data bits, 8-deep FIFO).
module tb_uart_xcvr_param;

  localparam int DATA_W  = 8;
  localparam int DIV_W   = 16;
  localparam int FIFO_AW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DIV_W-1:0]  cfg_div;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [FIFO_AW:0]  tx_level;
  logic              tx_busy;
  logic              tx_pin;
  logic              rx_pin;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_frame_err;
  logic              rx_parity_err;
  logic              rx_overrun;

  logic loop_sel;
  logic rx_drive;

  int tests_run    = 0;
  int tests_failed = 0;

  assign rx_pin = loop_sel ? tx_pin : rx_drive;

  always #5 clk = ~clk;

  uart_xcvr_param #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_level(tx_level), .tx_busy(tx_busy), .tx_pin(tx_pin),
    .rx_pin(rx_pin), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line image, bit 0 first on the wire; unused high bits idle at 1
  function automatic logic [15:0] mkFrame(input logic [7:0] d, input logic [1:0] par);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (par == 2'b01) f[9] = ~^d;
    else if (par == 2'b10) f[9] = ^d;
    return f;
  endfunction

  function automatic int frameLen(input logic [1:0] par, input logic stop2);
    return 10 + ((par == 2'b01 || par == 2'b10) ? 1 : 0) + (stop2 ? 1 : 0);
  endfunction

  task automatic applyStimulus(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Called on the first clock of a start bit; checks first and last clock of every bit
  task automatic checkTxFrame(input string tag, input logic [15:0] f, input int len, input int div);
    for (int k = 0; k < len; k++) begin
      checkOutput($sformatf("%s_b%0d_first", tag, k), tx_pin, f[k]);
      repeat (div) tick();
      checkOutput($sformatf("%s_b%0d_last", tag, k), tx_pin, f[k]);
      tick();
    end
  endtask

  task automatic txFrameTest(input string tag, input logic [7:0] d, input logic [1:0] par, input logic s2);
    cfg_parity = par;
    cfg_stop2  = s2;
    applyStimulus(d);
    checkOutput({tag, "_level"}, tx_level, 1);
    tick();
    checkTxFrame(tag, mkFrame(d, par), frameLen(par, s2), int'(cfg_div));
    checkOutput({tag, "_busy_end"}, tx_busy, 0);
    checkOutput({tag, "_pin_idle"}, tx_pin, 1);
  endtask

  task automatic sendRxFrame(input logic [15:0] f, input int len, input int div);
    for (int k = 0; k < len; k++) begin
      rx_drive = f[k];
      repeat (div + 1) tick();
    end
  endtask

  task automatic waitRxValid(input string tag, input int limit);
    for (int i = 0; i < limit && !rx_valid; i++) tick();
    checkOutput({tag, "_rx_valid"}, rx_valid, 1);
  endtask

  task automatic consumeRx(input string tag);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checkOutput({tag, "_rx_cleared"}, rx_valid, 0);
  endtask

  // Hang guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    logic [15:0] f;
    int idx;
    int cycles;
    logic rdy;

    rst_n = 1'b0; cfg_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; loop_sel = 1'b0; rx_drive = 1'b1;
    repeat (3) tick();
    checkOutput("rst_tx_pin", tx_pin, 1);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_tx_level", tx_level, 0);
    checkOutput("rst_tx_busy", tx_busy, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    checkOutput("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    rst_n = 1'b1;
    tick();

    // T1: 8N1 loopback of 0xA5
    loop_sel = 1'b1;
    txFrameTest("t1", 8'hA5, 2'b00, 1'b0);
    waitRxValid("t1", 20);
    checkOutput("t1_rx_data", rx_data, 8'hA5);
    checkOutput("t1_rx_errs", {rx_frame_err, rx_parity_err}, 0);
    consumeRx("t1");

    // T2: even parity, then odd parity with two stop bits, then bad parity on RX
    txFrameTest("t2_even", 8'h07, 2'b10, 1'b0);
    waitRxValid("t2_even", 20);
    checkOutput("t2_even_rx_data", rx_data, 8'h07);
    checkOutput("t2_even_perr", rx_parity_err, 0);
    consumeRx("t2_even");
    txFrameTest("t2_odd", 8'h07, 2'b01, 1'b1);
    waitRxValid("t2_odd", 20);
    checkOutput("t2_odd_rx_data", rx_data, 8'h07);
    checkOutput("t2_odd_perr", rx_parity_err, 0);
    consumeRx("t2_odd");
    loop_sel = 1'b0;
    cfg_parity = 2'b10;
    cfg_stop2 = 1'b0;
    f = mkFrame(8'h07, 2'b10);
    f[9] = ~f[9];
    sendRxFrame(f, 11, 3);
    waitRxValid("t2_bad", 20);
    checkOutput("t2_bad_rx_data", rx_data, 8'h07);
    checkOutput("t2_bad_perr", rx_parity_err, 1);
    checkOutput("t2_bad_ferr", rx_frame_err, 0);
    consumeRx("t2_bad");

    // T3: nine pushes with tx_valid held, then push-while-full, then back-to-back frames
    cfg_parity = 2'b00;
    idx = 0;
    cycles = 0;
    tx_valid = 1'b1;
    while (idx < 9 && cycles < 40) begin
      tx_data = 8'(idx);
      rdy = tx_ready;
      tick();
      cycles++;
      if (rdy) idx++;
    end
    checkOutput("t3_cycles", cycles, 9);
    checkOutput("t3_full_ready", tx_ready, 0);
    checkOutput("t3_full_level", tx_level, 8);
    tx_data = 8'h5A;
    repeat (4) tick();
    tx_valid = 1'b0;
    checkOutput("t3_full_ignored", tx_level, 8);
    repeat (29) tick();
    checkOutput("t3_level_f1", tx_level, 7);
    for (int n = 1; n < 9; n++) begin
      checkTxFrame($sformatf("t3_f%0d", n), mkFrame(8'(n), 2'b00), 10, 3);
    end
    checkOutput("t3_busy_end", tx_busy, 0);
    checkOutput("t3_level_end", tx_level, 0);
    checkOutput("t3_pin_end", tx_pin, 1);

    // T4: overrun keeps the first byte
    sendRxFrame(mkFrame(8'h11, 2'b00), 10, 3);
    repeat (4) tick();
    checkOutput("t4_valid1", rx_valid, 1);
    checkOutput("t4_data1", rx_data, 8'h11);
    checkOutput("t4_ovr1", rx_overrun, 0);
    sendRxFrame(mkFrame(8'h22, 2'b00), 10, 3);
    repeat (4) tick();
    checkOutput("t4_data2", rx_data, 8'h11);
    checkOutput("t4_ovr2", rx_overrun, 1);
    consumeRx("t4");
    checkOutput("t4_ovr_sticky", rx_overrun, 1);

    // T5: glitch rejection, then low stop bit held as a break
    cfg_div = 16'd15;
    rx_drive = 1'b0;
    repeat (2) tick();
    rx_drive = 1'b1;
    repeat (40) tick();
    checkOutput("t5_glitch", rx_valid, 0);
    f = mkFrame(8'h3C, 2'b00);
    f[9] = 1'b0;
    sendRxFrame(f, 10, 15);
    waitRxValid("t5_ferr", 40);
    checkOutput("t5_ferr_data", rx_data, 8'h3C);
    checkOutput("t5_ferr", rx_frame_err, 1);
    checkOutput("t5_ferr_perr", rx_parity_err, 0);
    consumeRx("t5");
    repeat (60) tick();
    rx_drive = 1'b1;
    repeat (40) tick();
    checkOutput("t5_break_no_retrigger", rx_valid, 0);

    // T6: reset in the middle of a frame with bytes queued
    cfg_div = 16'd3;
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    checkOutput("t6_level_q", tx_level, 2);
    repeat (8) tick();
    checkOutput("t6_busy_q", tx_busy, 1);
    rst_n = 1'b0;
    tick();
    checkOutput("t6_rst_pin", tx_pin, 1);
    checkOutput("t6_rst_level", tx_level, 0);
    checkOutput("t6_rst_busy", tx_busy, 0);
    checkOutput("t6_rst_ready", tx_ready, 1);
    checkOutput("t6_rst_ovr", rx_overrun, 0);
    rst_n = 1'b1;
    tick();
    loop_sel = 1'b1;
    txFrameTest("t6_after", 8'h3C, 2'b00, 1'b0);
    waitRxValid("t6_after", 20);
    checkOutput("t6_after_rx_data", rx_data, 8'h3C);
    consumeRx("t6_after");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
